// File: rtl/alu_control_muldiv.sv
// EX-stage ALU control: decodes alu_op/funct into a 4-bit ALU code and runs MULT/MULTU
// on an iterative shift-add multiplier that writes HI/LO, stalling the pipeline meanwhile.
module alu_control_muldiv #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [5:0]        function_field,
  input  logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  output logic [3:0]        alu_control,
  output logic [1:0]        result_sel,
  output logic              stall,
  output logic              mul_done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t state, state_next;

  logic [2*DATA_W-1:0] mcand;
  logic [DATA_W-1:0]   mplier;
  logic [2*DATA_W-1:0] acc;
  logic [CNT_W-1:0]    cnt;
  logic                neg;

  logic                is_mul;
  logic                is_signed;
  logic                last_iter;
  logic [DATA_W-1:0]   mag_a;
  logic [DATA_W-1:0]   mag_b;
  logic [2*DATA_W-1:0] partial;
  logic [2*DATA_W-1:0] acc_sum;
  logic [2*DATA_W-1:0] product;

  always_comb begin
    alu_control = '0;
    result_sel  = '0;
    case (alu_op)
      3'd0: alu_control = 4'd2;
      3'd1: alu_control = 4'd5;
      3'd2: begin
        case (function_field)
          F_ADD:   alu_control = 4'd2;
          F_SUB:   alu_control = 4'd5;
          F_AND:   alu_control = 4'd0;
          F_OR:    alu_control = 4'd1;
          F_NOR:   alu_control = 4'd12;
          F_SLT:   alu_control = 4'd7;
          F_SLL:   alu_control = 4'd3;
          F_SRL:   alu_control = 4'd4;
          F_MULT:  alu_control = 4'd8;
          F_MULTU: alu_control = 4'd8;
          F_MFHI: begin
            alu_control = 4'd2;
            result_sel  = 2'd1;
          end
          F_MFLO: begin
            alu_control = 4'd2;
            result_sel  = 2'd2;
          end
          default: alu_control = 4'd0;
        endcase
      end
      3'd3: alu_control = 4'd0;
      3'd4: alu_control = 4'd1;
      3'd5: alu_control = 4'd7;
      default: alu_control = 4'd0;
    endcase
  end

  assign is_mul    = valid_in && (alu_op == 3'd2) &&
                     ((function_field == F_MULT) || (function_field == F_MULTU));
  assign is_signed = (function_field == F_MULT);
  assign mag_a     = (is_signed && operand_a[DATA_W-1]) ? -operand_a : operand_a;
  assign mag_b     = (is_signed && operand_b[DATA_W-1]) ? -operand_b : operand_b;
  assign last_iter = (cnt == CNT_W'(DATA_W - 1));
  assign partial   = mplier[0] ? (mcand << cnt) : '0;
  assign acc_sum   = acc + partial;
  // Final add and sign fix-up happen combinationally so HI/LO land on the last BUSY edge.
  assign product   = neg ? -acc_sum : acc_sum;

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    mul_done   = 1'b0;
    case (state)
      S_IDLE: begin
        if (is_mul && !rst) begin
          stall      = 1'b1;
          state_next = S_BUSY;
        end
      end
      S_BUSY: begin
        stall = 1'b1;
        if (last_iter) state_next = S_DONE;
      end
      S_DONE: begin
        mul_done   = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (is_mul) begin
            mcand  <= {{DATA_W{1'b0}}, mag_a};
            mplier <= mag_b;
            neg    <= is_signed && (operand_a[DATA_W-1] ^ operand_b[DATA_W-1]);
            acc    <= '0;
            cnt    <= '0;
          end
        end
        S_BUSY: begin
          acc    <= acc_sum;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (last_iter) {hi, lo} <= product;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_control_muldiv.sv
// Bench for alu_control_muldiv at DATA_W = 8: decode sweep, directed and random multiplies
// against an arithmetic product model, mid-multiply reset, back-to-back and MFHI/MFLO.
module tb_alu_control_muldiv;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_in;
  logic [5:0]   function_field;
  logic [2:0]   alu_op;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic [3:0]   alu_control;
  logic [1:0]   result_sel;
  logic         stall;
  logic         mul_done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int total = 0;
  int bad   = 0;

  alu_control_muldiv #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .function_field(function_field),
    .alu_op(alu_op), .operand_a(operand_a), .operand_b(operand_b),
    .alu_control(alu_control), .result_sel(result_sel), .stall(stall),
    .mul_done(mul_done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference product: plain integer arithmetic on sign- or zero-extended operands.
  function automatic logic [2*W-1:0] ref_product(input logic [W-1:0] a, input logic [W-1:0] b,
                                                  input bit sgn);
    longint pa, pb, p;
    pa = sgn ? longint'($signed(a)) : longint'(a);
    pb = sgn ? longint'($signed(b)) : longint'(b);
    p  = pa * pb;
    return p[2*W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a multiply in the current (idle) cycle and follow it to DONE; returns in the
  // idle cycle after DONE with valid_in dropped.
  task automatic run_mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit sgn);
    logic [2*W-1:0] exp_p;
    int n_stall;
    int done_cyc;
    exp_p          = ref_product(a, b, sgn);
    valid_in       = 1'b1;
    alu_op         = 3'd2;
    function_field = sgn ? 6'b011000 : 6'b011001;
    operand_a      = a;
    operand_b      = b;
    n_stall        = 0;
    done_cyc       = 0;
    for (int i = 1; i <= 40; i++) begin
      #1;
      if (mul_done) begin
        done_cyc = i;
        break;
      end
      if (stall) n_stall++;
      if (i == 1) check({tag, "_ctl"}, 32'(alu_control), 32'd8);
      @(posedge clk);
      #1;
      operand_a = W'($urandom);
      operand_b = W'($urandom);
    end
    check({tag, "_stall_len"}, 32'(n_stall), 32'(W + 1));
    check({tag, "_done_cyc"}, 32'(done_cyc), 32'(W + 2));
    check({tag, "_done_stall"}, 32'(stall), 32'd0);
    check({tag, "_hilo"}, 32'({hi, lo}), 32'(exp_p));
    valid_in = 1'b0;
    tick();
    check({tag, "_idle_done"}, 32'(mul_done), 32'd0);
  endtask

  logic [3:0] op_codes [8];
  logic [5:0] fn_list  [13];
  logic [3:0] fn_codes [13];
  logic [1:0] fn_sel   [13];

  initial begin
    int seen;
    op_codes = '{4'd2, 4'd5, 4'd2, 4'd0, 4'd1, 4'd7, 4'd0, 4'd0};
    fn_list  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010, 6'b000000,
                 6'b000010, 6'b011000, 6'b011001, 6'b010000, 6'b010010, 6'b111111};
    fn_codes = '{4'd2, 4'd5, 4'd0, 4'd1, 4'd12, 4'd7, 4'd3, 4'd4, 4'd8, 4'd8, 4'd2, 4'd2, 4'd0};
    fn_sel   = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd0};

    rst            = 1'b1;
    valid_in       = 1'b1;
    alu_op         = 3'd2;
    function_field = 6'b011000;
    operand_a      = 8'd3;
    operand_b      = 8'd4;
    tick();
    tick();
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_done", 32'(mul_done), 32'd0);
    check("rst_hi", 32'(hi), 32'd0);
    check("rst_lo", 32'(lo), 32'd0);
    valid_in = 1'b0;
    rst      = 1'b0;
    tick();

    for (int op = 0; op < 8; op++) begin
      alu_op         = 3'(op);
      function_field = 6'b100000;
      #1;
      check($sformatf("op%0d_ctl", op), 32'(alu_control), 32'(op_codes[op]));
      check($sformatf("op%0d_sel", op), 32'(result_sel), 32'd0);
    end
    alu_op = 3'd2;
    for (int k = 0; k < 13; k++) begin
      function_field = fn_list[k];
      #1;
      check($sformatf("fn%0b_ctl", fn_list[k]), 32'(alu_control), 32'(fn_codes[k]));
      check($sformatf("fn%0b_sel", fn_list[k]), 32'(result_sel), 32'(fn_sel[k]));
    end
    check("sweep_stall", 32'(stall), 32'd0);
    tick();

    run_mul("m7x6", 8'd7, 8'd6, 1'b1);
    check("m7x6_hi", 32'(hi), 32'h00);
    check("m7x6_lo", 32'(lo), 32'h2A);
    run_mul("mneg3x5", 8'hFD, 8'h05, 1'b1);
    run_mul("muFFxFF", 8'hFF, 8'hFF, 1'b0);
    run_mul("m80x80", 8'h80, 8'h80, 1'b1);
    run_mul("m7x6b", 8'd7, 8'd6, 1'b1);

    valid_in       = 1'b1;
    alu_op         = 3'd2;
    function_field = 6'b011000;
    operand_a      = 8'd5;
    operand_b      = 8'd7;
    for (int i = 0; i < 4; i++) tick();
    check("busy4_stall", 32'(stall), 32'd1);
    rst      = 1'b1;
    valid_in = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check("abort_stall", 32'(stall), 32'd0);
    check("abort_done", 32'(mul_done), 32'd0);
    check("abort_hi", 32'(hi), 32'd0);
    check("abort_lo", 32'(lo), 32'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (mul_done || stall) seen++;
      tick();
    end
    check("abort_quiet", 32'(seen), 32'd0);
    run_mul("m3x3", 8'd3, 8'd3, 1'b1);
    check("m3x3_lo", 32'(lo), 32'd9);

    run_mul("m5x5", 8'd5, 8'd5, 1'b1);
    run_mul("m2x3", 8'd2, 8'd3, 1'b1);
    valid_in       = 1'b1;
    alu_op         = 3'd2;
    function_field = 6'b010010;
    #1;
    check("mflo_sel", 32'(result_sel), 32'd2);
    check("mflo_ctl", 32'(alu_control), 32'd2);
    check("mflo_lo", 32'(lo), 32'd6);
    check("mflo_stall", 32'(stall), 32'd0);
    tick();
    function_field = 6'b010000;
    #1;
    check("mfhi_sel", 32'(result_sel), 32'd1);
    check("mfhi_hi", 32'(hi), 32'd0);
    tick();

    valid_in       = 1'b1;
    alu_op         = 3'd3;
    function_field = 6'b011000;
    #1;
    check("nonr_stall", 32'(stall), 32'd0);
    tick();
    check("nonr_idle", 32'(stall), 32'd0);
    valid_in = 1'b0;

    for (int r = 0; r < 12; r++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        valid_in       = 1'($urandom);
        alu_op         = 3'd2;
        function_field = 6'b100000;
        tick();
      end
      run_mul($sformatf("rnd%0d", r), W'($urandom), W'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
